// File: rtl/gelato_types.sv
// Shared types and default sizing for the gelato warp scoreboard.
package gelato_types;
   localparam int DEF_WARP_NUM = 4;
   localparam int DEF_SB_DEPTH = 8;
   localparam int DEF_REG_W    = 5;
   localparam int DEF_WB_PORTS = 2;
   localparam int DEF_SRC_NUM  = 3;
   localparam int DEF_WARP_W   = $clog2(DEF_WARP_NUM);

   typedef logic [DEF_WARP_W-1:0] warp_num_t;
   typedef logic [DEF_REG_W-1:0]  reg_num_t;

   // Register 0 means "no register" and is never tracked.
   localparam reg_num_t REG_NONE = '0;

   typedef struct packed {
      logic      valid;
      warp_num_t warp;
      reg_num_t  regn;
   } gelato_sb_wb_t;
endpackage

// File: rtl/gelato_scoreboard_mc_if.sv
// Scheduler/writeback bus of the scoreboard; master = scheduler side, slave = scoreboard.
interface gelato_scoreboard_mc_if
   import gelato_types::*;
#(
   parameter int WARP_NUM = DEF_WARP_NUM,
   parameter int SB_DEPTH = DEF_SB_DEPTH,
   parameter int REG_W    = DEF_REG_W,
   parameter int WB_PORTS = DEF_WB_PORTS,
   parameter int SRC_NUM  = DEF_SRC_NUM
);
   localparam int WARP_W = (WARP_NUM > 1) ? $clog2(WARP_NUM) : 1;
   localparam int CNT_W  = $clog2(SB_DEPTH + 1);

   logic                        rdy;
   logic                        issue_valid;
   logic                        issue_ready;
   logic [WARP_W-1:0]           issue_warp;
   logic [REG_W-1:0]            issue_rd;
   logic [SRC_NUM*REG_W-1:0]    issue_rs;
   logic [WB_PORTS-1:0]         wb_valid;
   logic [WB_PORTS*WARP_W-1:0]  wb_warp;
   logic [WB_PORTS*REG_W-1:0]   wb_reg;
   logic [WARP_NUM-1:0]         warp_full;
   logic [WARP_NUM*CNT_W-1:0]   pending_cnt;
   logic                        err_spurious_wb;

   modport master (
      output rdy, issue_valid, issue_warp, issue_rd, issue_rs, wb_valid, wb_warp, wb_reg,
      input  issue_ready, warp_full, pending_cnt, err_spurious_wb
   );

   modport slave (
      input  rdy, issue_valid, issue_warp, issue_rd, issue_rs, wb_valid, wb_warp, wb_reg,
      output issue_ready, warp_full, pending_cnt, err_spurious_wb
   );
endinterface

// File: rtl/gelato_sb_prio_enc.sv
// Lowest-set-bit encoder; the scoreboard feeds it inverted slot valids to find a free slot.
module gelato_sb_prio_enc #(
   parameter int  N     = 8,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   output logic             found_o,
   output logic [IDX_W-1:0] idx_o
);
   // NOTE: every output gets a default before the loop so no latch is inferred.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            found_o = 1'b1;
            idx_o   = IDX_W'(i);
         end
      end
   end
endmodule

// File: rtl/gelato_scoreboard_mc.sv
// Multi-warp, multi-writeback scoreboard: stalls issue on RAW/WAW hazards or a full warp table.
// Define GELATO_SCOREBOARD_WB_BYPASS_EN to let same-cycle writebacks mask hazards.
module gelato_scoreboard_mc
   import gelato_types::*;
#(
   parameter int WARP_NUM = DEF_WARP_NUM,
   parameter int SB_DEPTH = DEF_SB_DEPTH,
   parameter int REG_W    = DEF_REG_W,
   parameter int WB_PORTS = DEF_WB_PORTS,
   parameter int SRC_NUM  = DEF_SRC_NUM
) (
   input logic                   clk,
   input logic                   rst_n,
   gelato_scoreboard_mc_if.slave sb
);
   localparam int WARP_W = (WARP_NUM > 1) ? $clog2(WARP_NUM) : 1;
   localparam int SLOT_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
   localparam int CNT_W  = $clog2(SB_DEPTH + 1);

   logic [WARP_NUM-1:0][SB_DEPTH-1:0] valid_q, valid_d, clr;
   logic [REG_W-1:0]                  reg_q [WARP_NUM][SB_DEPTH];
   logic [WARP_NUM-1:0][CNT_W-1:0]    cnt_q, cnt_d;
   logic [WARP_NUM-1:0]               full_q, full_d;
   logic                              err_q;

   gelato_sb_wb_t       wb [WB_PORTS];
   logic [WB_PORTS-1:0] wb_hit;
   logic                spurious;
   logic [SB_DEPTH-1:0] live;
   logic                hazard, ready, alloc, free_found;
   logic [SLOT_W-1:0]   free_idx;

   always_comb begin
      for (int p = 0; p < WB_PORTS; p++) begin
         wb[p].regn  = sb.wb_reg[p*REG_W +: REG_W];
         wb[p].warp  = sb.wb_warp[p*WARP_W +: WARP_W];
         wb[p].valid = sb.wb_valid[p] & sb.rdy & (sb.wb_reg[p*REG_W +: REG_W] != REG_NONE);
      end
   end

   // Ports hitting the same entry simply OR into one clear bit.
   always_comb begin
      clr      = '0;
      wb_hit   = '0;
      spurious = 1'b0;
      for (int p = 0; p < WB_PORTS; p++) begin
         for (int w = 0; w < WARP_NUM; w++) begin
            for (int s = 0; s < SB_DEPTH; s++) begin
               if (wb[p].valid && wb[p].warp == warp_num_t'(w) && valid_q[w][s] &&
                   reg_q[w][s] == wb[p].regn) begin
                  clr[w][s] = 1'b1;
                  wb_hit[p] = 1'b1;
               end
            end
         end
         if (wb[p].valid && !wb_hit[p]) spurious = 1'b1;
      end
   end

   always_comb begin
      live = valid_q[sb.issue_warp];
`ifdef GELATO_SCOREBOARD_WB_BYPASS_EN
      live = live & ~clr[sb.issue_warp];
`endif
      hazard = 1'b0;
      for (int s = 0; s < SB_DEPTH; s++) begin
         if (live[s]) begin
            if (sb.issue_rd != REG_NONE && reg_q[sb.issue_warp][s] == sb.issue_rd) hazard = 1'b1;
            for (int k = 0; k < SRC_NUM; k++) begin
               if (sb.issue_rs[k*REG_W +: REG_W] != REG_NONE &&
                   reg_q[sb.issue_warp][s] == sb.issue_rs[k*REG_W +: REG_W]) hazard = 1'b1;
            end
         end
      end
   end

   assign ready = rst_n & sb.rdy & ~hazard & ~((sb.issue_rd != REG_NONE) & full_q[sb.issue_warp]);
   assign alloc = sb.issue_valid & ready & (sb.issue_rd != REG_NONE) & free_found;

   // Free slot is picked from pre-clear valids, so it never lands on a slot freed this cycle.
   gelato_sb_prio_enc #(.N(SB_DEPTH)) u_free_slot (
      .req_i   (~valid_q[sb.issue_warp]),
      .found_o (free_found),
      .idx_o   (free_idx)
   );

   always_comb begin
      valid_d = valid_q & ~clr;
      if (alloc) valid_d[sb.issue_warp][free_idx] = 1'b1;
      for (int w = 0; w < WARP_NUM; w++) begin
         cnt_d[w] = '0;
         for (int s = 0; s < SB_DEPTH; s++) cnt_d[w] = cnt_d[w] + CNT_W'(valid_d[w][s]);
         full_d[w] = (cnt_d[w] == CNT_W'(SB_DEPTH));
      end
   end

   // NOTE: reg_q is reset too so slot contents are never X; sequential state uses <= only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         cnt_q   <= '0;
         full_q  <= '0;
         err_q   <= 1'b0;
         for (int w = 0; w < WARP_NUM; w++) begin
            for (int s = 0; s < SB_DEPTH; s++) reg_q[w][s] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         full_q  <= full_d;
         err_q   <= err_q | spurious;
         if (alloc) reg_q[sb.issue_warp][free_idx] <= sb.issue_rd;
      end
   end

   assign sb.issue_ready     = ready;
   assign sb.warp_full       = full_q;
   assign sb.pending_cnt     = cnt_q;
   assign sb.err_spurious_wb = err_q;
endmodule

// File: tb/tb_gelato_scoreboard_mc.sv
// Self-checking bench for gelato_scoreboard_mc: vector table, corner sequences, random vs queue model.
module tb_gelato_scoreboard_mc;
   localparam int WN = 4;
   localparam int SD = 8;
   localparam int RW = 5;
   localparam int WP = 2;
   localparam int SN = 3;
`ifdef GELATO_SCOREBOARD_WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   gelato_scoreboard_mc_if #(.WARP_NUM(WN), .SB_DEPTH(SD), .REG_W(RW), .WB_PORTS(WP), .SRC_NUM(SN)) sb ();

   gelato_scoreboard_mc #(.WARP_NUM(WN), .SB_DEPTH(SD), .REG_W(RW), .WB_PORTS(WP), .SRC_NUM(SN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sb    (sb)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Model: per-warp list of pending register numbers plus the sticky error flag.
   int pend [WN][$];
   bit err_m;

   typedef struct {
      bit         rdy, v;
      int         w, rd;
      logic [14:0] rs;
      logic [1:0] wv;
      int         ww0, wr0, ww1, wr1;
      bit         e_ready;
      logic [15:0] e_cnt;
      logic [3:0] e_full;
      bit         e_err;
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit r, input bit v, input int w, input int rd, input logic [14:0] rs,
                        input logic [1:0] wv, input int ww0, input int wr0, input int ww1, input int wr1);
      sb.rdy         = r;
      sb.issue_valid = v;
      sb.issue_warp  = 2'(w);
      sb.issue_rd    = 5'(rd);
      sb.issue_rs    = rs;
      sb.wb_valid    = wv;
      sb.wb_warp     = {2'(ww1), 2'(ww0)};
      sb.wb_reg      = {5'(wr1), 5'(wr0)};
   endtask

   task automatic add_vec(input bit r, input bit v, input int w, input int rd, input logic [14:0] rs,
                          input logic [1:0] wv, input int ww0, input int wr0, input int ww1, input int wr1,
                          input bit e_ready, input logic [15:0] e_cnt, input logic [3:0] e_full, input bit e_err);
      vec_t t;
      t.rdy = r; t.v = v; t.w = w; t.rd = rd; t.rs = rs; t.wv = wv;
      t.ww0 = ww0; t.wr0 = wr0; t.ww1 = ww1; t.wr1 = wr1;
      t.e_ready = e_ready; t.e_cnt = e_cnt; t.e_full = e_full; t.e_err = e_err;
      vecs.push_back(t);
   endtask

   function automatic bit has(input int w, input int r);
      for (int i = 0; i < pend[w].size(); i++) if (pend[w][i] == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit wb_clears(input int w, input int r);
      for (int p = 0; p < WP; p++)
         if (sb.rdy && sb.wb_valid[p] && r != 0 && int'(sb.wb_reg[p*RW +: RW]) == r &&
             int'(sb.wb_warp[p*2 +: 2]) == w) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit model_ready();
      int w  = int'(sb.issue_warp);
      int rd = int'(sb.issue_rd);
      bit hz = 1'b0;
      if (!rst_n || !sb.rdy) return 1'b0;
      for (int i = 0; i < pend[w].size(); i++) begin
         int r = pend[w][i];
         if (!(BYPASS && wb_clears(w, r))) begin
            if (rd != 0 && r == rd) hz = 1'b1;
            for (int k = 0; k < SN; k++) begin
               int s = int'(sb.issue_rs[k*RW +: RW]);
               if (s != 0 && s == r) hz = 1'b1;
            end
         end
      end
      if (hz) return 1'b0;
      if (rd != 0 && pend[w].size() == SD) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [15:0] exp_cnt();
      logic [15:0] c = '0;
      for (int w = 0; w < WN; w++) c[w*4 +: 4] = 4'(pend[w].size());
      return c;
   endfunction

   function automatic logic [3:0] exp_full();
      logic [3:0] f = '0;
      for (int w = 0; w < WN; w++) f[w] = (pend[w].size() == SD);
      return f;
   endfunction

   task automatic model_clear();
      for (int w = 0; w < WN; w++) pend[w].delete();
      err_m = 1'b0;
   endtask

   task automatic model_edge();
      bit acc;
      int w, rd, ww, wr;
      acc = model_ready() && sb.issue_valid;
      w   = int'(sb.issue_warp);
      rd  = int'(sb.issue_rd);
      if (!rst_n) begin
         model_clear();
         return;
      end
      if (!sb.rdy) return;
      for (int p = 0; p < WP; p++) begin
         ww = int'(sb.wb_warp[p*2 +: 2]);
         wr = int'(sb.wb_reg[p*RW +: RW]);
         if (sb.wb_valid[p] && wr != 0 && !has(ww, wr)) err_m = 1'b1;
      end
      for (int p = 0; p < WP; p++) begin
         ww = int'(sb.wb_warp[p*2 +: 2]);
         wr = int'(sb.wb_reg[p*RW +: RW]);
         if (sb.wb_valid[p] && wr != 0)
            for (int i = pend[ww].size() - 1; i >= 0; i--) if (pend[ww][i] == wr) pend[ww].delete(i);
      end
      if (acc && rd != 0) pend[w].push_back(rd);
   endtask

   task automatic settle();
      @(negedge clk);
      check("issue_ready", {31'd0, sb.issue_ready}, {31'd0, model_ready()});
      check("pending_cnt", {16'd0, sb.pending_cnt}, {16'd0, exp_cnt()});
      check("warp_full", {28'd0, sb.warp_full}, {28'd0, exp_full()});
      check("err_spurious_wb", {31'd0, sb.err_spurious_wb}, {31'd0, err_m});
   endtask

   task automatic advance();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   function automatic int pick_reg(input int w);
      if (pend[w].size() > 0 && $urandom_range(0, 3) != 0)
         return pend[w][$urandom_range(0, pend[w].size() - 1)];
      return int'($urandom_range(0, 15));
   endfunction

   initial begin
      model_clear();
      drive(1, 0, 0, 0, 15'd0, 2'b00, 0, 0, 0, 0);

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      settle();
      check("reset issue_ready", {31'd0, sb.issue_ready}, 32'd0);
      check("reset pending_cnt", {16'd0, sb.pending_cnt}, 32'd0);
      advance();
      rst_n = 1'b1;

      // rdy v w rd rs | wv ww0 wr0 ww1 wr1 | ready cnt full err
      add_vec(1, 0, 0, 0, 15'd0, 2'b00, 0, 0, 0, 0, 1, 16'h0000, 4'h0, 0);
      add_vec(1, 1, 1, 5, 15'd0, 2'b00, 0, 0, 0, 0, 1, 16'h0000, 4'h0, 0);
      add_vec(1, 0, 1, 0, 15'd5, 2'b00, 0, 0, 0, 0, 0, 16'h0010, 4'h0, 0);
      add_vec(1, 0, 0, 0, 15'd5, 2'b00, 0, 0, 0, 0, 1, 16'h0010, 4'h0, 0);
      add_vec(1, 1, 0, 4, 15'd0, 2'b00, 0, 0, 0, 0, 1, 16'h0010, 4'h0, 0);
      add_vec(1, 1, 0, 6, 15'd0, 2'b00, 0, 0, 0, 0, 1, 16'h0011, 4'h0, 0);
      add_vec(1, 1, 3, 4, 15'd0, 2'b00, 0, 0, 0, 0, 1, 16'h0012, 4'h0, 0);
      add_vec(1, 0, 0, 0, 15'd0, 2'b11, 0, 4, 0, 6, 1, 16'h1012, 4'h0, 0);
      add_vec(1, 0, 0, 0, 15'd4, 2'b00, 0, 0, 0, 0, 1, 16'h1010, 4'h0, 0);
      add_vec(1, 0, 3, 0, 15'd4, 2'b00, 0, 0, 0, 0, 0, 16'h1010, 4'h0, 0);
      add_vec(1, 0, 0, 0, 15'd0, 2'b01, 1, 7, 0, 0, 1, 16'h1010, 4'h0, 0);
      add_vec(1, 0, 0, 0, 15'd0, 2'b00, 0, 0, 0, 0, 1, 16'h1010, 4'h0, 1);
      add_vec(1, 0, 0, 0, 15'd0, 2'b01, 1, 5, 0, 0, 1, 16'h1010, 4'h0, 1);
      add_vec(1, 0, 0, 0, 15'd0, 2'b00, 0, 0, 0, 0, 1, 16'h1000, 4'h0, 1);
      add_vec(0, 1, 0, 8, 15'd0, 2'b01, 3, 4, 0, 0, 0, 16'h1000, 4'h0, 1);
      add_vec(1, 0, 0, 0, 15'd0, 2'b00, 0, 0, 0, 0, 1, 16'h1000, 4'h0, 1);
      add_vec(1, 0, 3, 0, 15'd4, 2'b00, 0, 0, 0, 0, 0, 16'h1000, 4'h0, 1);

      foreach (vecs[i]) begin
         drive(vecs[i].rdy, vecs[i].v, vecs[i].w, vecs[i].rd, vecs[i].rs, vecs[i].wv,
               vecs[i].ww0, vecs[i].wr0, vecs[i].ww1, vecs[i].wr1);
         @(negedge clk);
         check($sformatf("vec%0d ready", i), {31'd0, sb.issue_ready}, {31'd0, vecs[i].e_ready});
         check($sformatf("vec%0d cnt", i), {16'd0, sb.pending_cnt}, {16'd0, vecs[i].e_cnt});
         check($sformatf("vec%0d full", i), {28'd0, sb.warp_full}, {28'd0, vecs[i].e_full});
         check($sformatf("vec%0d err", i), {31'd0, sb.err_spurious_wb}, {31'd0, vecs[i].e_err});
         advance();
      end

      // Fill warp 2, back-pressure, then free one slot and refill it.
      for (int r = 1; r <= SD; r++) begin
         drive(1, 1, 2, r, 15'd0, 2'b00, 0, 0, 0, 0);
         settle();
         check("fill ready", {31'd0, sb.issue_ready}, 32'd1);
         advance();
      end
      drive(1, 1, 2, 9, 15'd0, 2'b00, 0, 0, 0, 0);
      settle();
      check("full flag w2", {31'd0, sb.warp_full[2]}, 32'd1);
      check("full cnt w2", {28'd0, sb.pending_cnt[11:8]}, 32'd8);
      check("full blocks rd9", {31'd0, sb.issue_ready}, 32'd0);
      advance();
      drive(1, 1, 2, 0, 15'd10, 2'b00, 0, 0, 0, 0);
      settle();
      check("full allows rd0", {31'd0, sb.issue_ready}, 32'd1);
      advance();
      drive(1, 0, 2, 0, 15'd0, 2'b01, 2, 3, 0, 0);
      settle();
      advance();
      drive(1, 1, 2, 9, 15'd0, 2'b00, 0, 0, 0, 0);
      settle();
      check("unfull w2", {31'd0, sb.warp_full[2]}, 32'd0);
      check("refill ready", {31'd0, sb.issue_ready}, 32'd1);
      advance();
      drive(1, 0, 2, 0, 15'd9, 2'b00, 0, 0, 0, 0);
      settle();
      check("refull w2", {31'd0, sb.warp_full[2]}, 32'd1);
      check("rd9 pending", {31'd0, sb.issue_ready}, 32'd0);
      advance();
      drive(1, 0, 2, 0, 15'd3, 2'b00, 0, 0, 0, 0);
      settle();
      check("rd3 gone", {31'd0, sb.issue_ready}, 32'd1);
      advance();
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 0, 15'd0, 2'b11, 2, (i == 0) ? 1 : 2 * i + 2, 2, (i == 0) ? 2 : 2 * i + 3);
         settle();
         advance();
      end
      drive(1, 0, 0, 0, 15'd0, 2'b00, 0, 0, 0, 0);
      settle();
      check("drained w2", {28'd0, sb.pending_cnt[11:8]}, 32'd0);
      advance();

      // Writeback and dependent issue of the same warp/reg in one cycle.
      drive(1, 1, 0, 4, 15'd0, 2'b00, 0, 0, 0, 0);
      settle();
      advance();
      drive(1, 1, 0, 0, 15'd4, 2'b01, 0, 4, 0, 0);
      settle();
      check("same-cycle wb ready", {31'd0, sb.issue_ready}, {31'd0, BYPASS});
      advance();
      drive(1, 1, 0, 0, 15'd4, 2'b00, 0, 0, 0, 0);
      settle();
      check("after wb ready", {31'd0, sb.issue_ready}, 32'd1);
      advance();

      // Randomised traffic against the queue model.
      for (int c = 0; c < 600; c++) begin
         int w, rd, ww0, ww1;
         logic [14:0] rs;
         logic [1:0] wv;
         w   = int'($urandom_range(0, 3));
         rd  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
         for (int k = 0; k < SN; k++) rs[k*RW +: RW] = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'(pick_reg(w));
         ww0 = int'($urandom_range(0, 3));
         ww1 = ($urandom_range(0, 3) == 0) ? w : int'($urandom_range(0, 3));
         wv  = {($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3)};
         drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, w, rd, rs, wv,
               ww0, pick_reg(ww0), ww1, pick_reg(ww1));
         settle();
         advance();
      end

      // Reset mid-operation with five entries pending.
      drive(1, 0, 0, 0, 15'd0, 2'b00, 0, 0, 0, 0);
      rst_n = 1'b0;
      model_clear();
      advance();
      rst_n = 1'b1;
      drive(1, 1, 0, 1, 15'd0, 2'b00, 0, 0, 0, 0); settle(); advance();
      drive(1, 1, 1, 2, 15'd0, 2'b00, 0, 0, 0, 0); settle(); advance();
      drive(1, 1, 2, 3, 15'd0, 2'b00, 0, 0, 0, 0); settle(); advance();
      drive(1, 1, 3, 4, 15'd0, 2'b00, 0, 0, 0, 0); settle(); advance();
      drive(1, 1, 3, 5, 15'd0, 2'b00, 0, 0, 0, 0); settle(); advance();
      drive(1, 0, 3, 0, 15'd5, 2'b00, 0, 0, 0, 0);
      settle();
      check("pre-reset cnt", {16'd0, sb.pending_cnt}, 32'h2111);
      check("pre-reset hazard", {31'd0, sb.issue_ready}, 32'd0);
      advance();
      rst_n = 1'b0;
      model_clear();
      #1;
      check("async reset cnt", {16'd0, sb.pending_cnt}, 32'd0);
      check("async reset full", {28'd0, sb.warp_full}, 32'd0);
      check("async reset ready", {31'd0, sb.issue_ready}, 32'd0);
      check("async reset err", {31'd0, sb.err_spurious_wb}, 32'd0);
      settle();
      advance();
      rst_n = 1'b1;
      drive(1, 1, 3, 0, 15'd5, 2'b00, 0, 0, 0, 0);
      settle();
      check("post-reset w3 rs5", {31'd0, sb.issue_ready}, 32'd1);
      advance();
      drive(1, 1, 0, 1, 15'd0, 2'b00, 0, 0, 0, 0);
      settle();
      check("post-reset w0 rd1", {31'd0, sb.issue_ready}, 32'd1);
      advance();
      drive(1, 0, 0, 0, 15'd0, 2'b00, 0, 0, 0, 0);
      settle();
      check("post-reset cnt", {16'd0, sb.pending_cnt}, 32'h0001);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/gelato_scoreboard_mc.md
Name: gelato_scoreboard_mc

Overview:
- Parametrised multi-warp, multi-writeback-port scoreboard between the warp scheduler and the dispatch/issue stage.
- Tracks pending destination registers per warp. Blocks issue on RAW and WAW hazards and on a full per-warp table.
- Clears entries from several writeback channels per cycle, matched by warp and register.
- Replaces the single-port, warp-agnostic scoreboard. Writeback now clears only the owning warp's entries, and fullness is handled by backpressure instead of a fatal.

Parameters:
- WARP_NUM, 4, number of warps tracked.
- SB_DEPTH, 8, pending-register slots per warp.
- REG_W, 5, register-number width; register 0 means "none" and is never tracked.
- WB_PORTS, 2, independent writeback channels.
- SRC_NUM, 3, source operands checked per issue.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- rdy  in  1  global enable; when 0, state holds and issue_ready=0.
- issue_valid  in  1  scheduler presents an instruction.
- issue_ready  out  1  instruction accepted this cycle.
- issue_warp  in  $clog2(WARP_NUM)  warp of the instruction.
- issue_rd  in  REG_W  destination register (0 = none).
- issue_rs  in  SRC_NUM*REG_W  packed source registers (0 = unused).
- wb_valid  in  WB_PORTS  per-channel writeback strobe.
- wb_warp  in  WB_PORTS*$clog2(WARP_NUM)  per-channel warp.
- wb_reg  in  WB_PORTS*REG_W  per-channel register.
- warp_full  out  WARP_NUM  per-warp table full.
- pending_cnt  out  WARP_NUM*$clog2(SB_DEPTH+1)  per-warp occupied-slot count.
- err_spurious_wb  out  1  sticky flag: a writeback matched no pending entry.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. On reset:
  - all slot valids = 0, all slot regs = 0;
  - warp_full = 0, pending_cnt = 0, err_spurious_wb = 0;
  - issue_ready is combinationally 0 while in reset.
- Reset mid-operation discards every pending entry immediately. There is no drain.
- Storage: per warp w, slot s holds valid[w][s] and reg[w][s].
- Hazard (combinational, current registered state only): a valid entry in issue_warp equals any nonzero issue_rs[k] (RAW) or a nonzero issue_rd (WAW).
- issue_ready = rdy & !hazard & !(issue_rd != 0 & warp_full[issue_warp]).
  - It is independent of issue_valid, so the scheduler may probe it.
  - An instruction with rd=0 is not blocked by warp_full.
- Accept = issue_valid & issue_ready.
  - If issue_rd != 0: the lowest-index invalid slot of issue_warp is written (valid=1, reg=issue_rd) at the next clk edge.
  - The entry is visible to hazard checks from the next cycle (1-cycle latency).
- Writeback: for each p with wb_valid[p] & rdy, every valid entry of warp wb_warp[p] whose reg equals wb_reg[p] is cleared at the next edge.
  - Other warps are untouched.
  - wb_reg = 0 is ignored.
- Simultaneous events:
  - Two ports clearing the same entry produce a single clear.
  - Allocation and writeback in one cycle: the allocation slot is chosen from pre-clear state, so it never collides with a slot being freed. The freed slot is reusable next cycle.
  - A writeback and an issue of the same warp/reg in the same cycle: the hazard uses pre-clear state, so the issue stalls one cycle.
- pending_cnt[w] and warp_full[w] (= pending_cnt[w]==SB_DEPTH) are registered and updated in the same edge as the slot changes.
  - pending_cnt[w] = old count + allocate - number of distinct slots cleared.
- err_spurious_wb: set when a valid nonzero writeback matches no valid entry of its warp. Cleared only by reset.

Optional Feature:
- Macro: GELATO_SCOREBOARD_WB_BYPASS_EN.
- When defined: the hazard compare masks entries being cleared by a same-cycle writeback. An issue depending on a register written back in the same cycle is accepted without the 1-cycle stall. The slot-choice rule is unchanged.
- When undefined: behaviour is exactly as above.

Decomposition:
- Shared gelato_types package:
  - warp_num_t, reg_num_t (REG_W);
  - a struct gelato_sb_wb_t {valid, warp, reg};
  - constant REG_NONE = 0.
- One natural sub-module: gelato_sb_prio_enc, a parametrised lowest-set-bit encoder used for free-slot selection. It takes the inverted valid vector of a warp and returns {found, index}.

Test Plan:
- Reset, then issue warp1 rd=5 -> issue_ready=1; next cycle pending_cnt[1]=1. Then issue warp1 rs={5,0,0} -> issue_ready=0. Issue warp0 rs={5,0,0} -> issue_ready=1.
- Fill warp2 with rd=1..8 (SB_DEPTH=8) -> warp_full[2]=1. Next issue rd=9 -> issue_ready=0. Issue rd=0, rs=10 -> accepted. Writeback warp2 reg3 -> warp_full[2]=0 next cycle, and rd=9 lands in slot 2.
- Pending warp0 regs 4 and 6. Assert wb port0 (w0,r4) and port1 (w0,r6) in one cycle -> pending_cnt[0] goes 2->0; a warp3 entry for reg 4 stays pending.
- Writeback warp0 r4 and issue warp0 rs=4 in the same cycle -> without the macro, issue_ready=0 that cycle and 1 next cycle; with GELATO_SCOREBOARD_WB_BYPASS_EN, issue_ready=1 in the same cycle.
- Writeback warp1 r7 with no entry pending -> err_spurious_wb=1 from the next cycle and held until rst_n is asserted.
- Assert rst_n low with 5 entries pending across warps -> all pending_cnt=0, warp_full=0, issue_ready=0 during reset; after release, previously hazarding issues are accepted.
